// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding and parity_mode codes.
// Combinational only; no latency.
// No flow control of its own; used by axis_to_uart_tx and its sub-modules.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // PARITY only exists when the parity feature is compiled in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AXIS_TO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-clock tick at the end of every BAUD_COUNT-clock bit.
// restart zeroes the count so the first tick lands BAUD_COUNT clocks later.
// No backpressure; free-running between restarts.
module uart_baud_gen #(
    parameter int BAUD_COUNT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(BAUD_COUNT);
    localparam logic [CW-1:0] LAST = CW'(BAUD_COUNT - 1);

    logic [CW-1:0] cnt;

    // Count 0..BAUD_COUNT-1 and wrap; a restart realigns to the start of a bit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick is decoded from the count alone so the FSM can use it to decide a restart.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/axis_to_uart_tx.sv
// AXI-stream to UART transmitter with FIFO_DEPTH-entry buffer and CTS flow control; parity via AXIS_TO_UART_TX_PARITY_EN.
// Latency: txd falls on the third rising edge after the accepting edge (FIFO empty, ctsn low).
// Backpressure: iready drops when the FIFO is full; frames only start while synchronized ctsn is low.
module axis_to_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [DATA_BITS-1:0]          idata,
    input  logic                          ivalid,
    output logic                          iready,
    input  logic [1:0]                    parity_mode,
    output logic                          txd,
    input  logic                          ctsn,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    // ---------------- ctsn synchronizer ----------------
    logic cts_meta;
    logic cts_sync;

    // Two flops reset to "deasserted" so nothing is sent until ctsn is seen low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= ctsn;
            cts_sync <= cts_meta;
        end
    end

    // ---------------- input FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level_nxt;
    logic [LW-1:0]        avail;
    logic [LW-1:0]        avail_nxt;
    logic [1:0]           push_d;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] rd_data;

    assign push    = ivalid && iready;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= idata;
        end
    end

    // Occupancy seen by the stream side, and occupancy visible to the transmitter.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = level - LW'(1);
        end
        avail_nxt = avail;
        if (push_d[1] && !pop) begin
            avail_nxt = avail + LW'(1);
        end else if (!push_d[1] && pop) begin
            avail_nxt = avail - LW'(1);
        end
    end

    // Pointers, counts and registered iready. A written entry becomes eligible
    // for transmission two clocks after its write, which fixes the accept-to-start
    // latency at three clocks; avail never exceeds level, so pops never underflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            avail  <= '0;
            push_d <= '0;
            iready <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level_nxt;
            avail  <= avail_nxt;
            push_d <= {push_d[0], push};
            iready <= (level_nxt != FULL);
        end
    end

    // ---------------- baud timing ----------------
    logic tick;
    logic start_frame;

    uart_baud_gen #(
        .BAUD_COUNT (BAUD_COUNT)
    ) u_baud (
        .clock   (clock),
        .resetn  (resetn),
        .restart (start_frame),
        .tick    (tick)
    );

    // ---------------- frame FSM ----------------
    uart_state_t          state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic                 last_stop;

`ifdef AXIS_TO_UART_TX_PARITY_EN
    logic par_en;
    logic par_bit;
`else
    wire unused_parity_mode = ^parity_mode;
`endif

    // A frame starts from IDLE, or directly from the end of the last stop bit
    // so queued words go out with no idle clocks between them.
    always_comb begin
        last_stop   = (state == STOP) && tick && (bit_idx == LAST_STOP);
        start_frame = (avail != '0) && !cts_sync && ((state == IDLE) || last_stop);
        pop         = start_frame;
    end

    // Frame sequencing with registered txd/busy; a new start overrides everything.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            txd     <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef AXIS_TO_UART_TX_PARITY_EN
            par_en  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else if (start_frame) begin
            state   <= START;
            txd     <= 1'b0;
            busy    <= 1'b1;
            shreg   <= rd_data;
            bit_idx <= '0;
`ifdef AXIS_TO_UART_TX_PARITY_EN
            par_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit <= (parity_mode == PAR_ODD) ? ~(^rd_data) : (^rd_data);
`endif
        end else if (tick) begin
            case (state)
                START: begin
                    state   <= DATA;
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (bit_idx == LAST_DATA) begin
                        bit_idx <= '0;
`ifdef AXIS_TO_UART_TX_PARITY_EN
                        if (par_en) begin
                            state <= PARITY;
                            txd   <= par_bit;
                        end else begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
`else
                        state <= STOP;
                        txd   <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
`ifdef AXIS_TO_UART_TX_PARITY_EN
                PARITY: begin
                    state   <= STOP;
                    txd     <= 1'b1;
                    bit_idx <= '0;
                end
`endif
                STOP: begin
                    if (bit_idx == LAST_STOP) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Testbench for axis_to_uart_tx: an 8N1 instance and a 5-data/2-stop instance at 16 clocks per bit.
// Expected line waveforms come from a frame-building model of the UART framing rules.
// Randomized words and parity modes plus directed latency, full-FIFO, CTS and reset scenarios.
module tb_axis_to_uart_tx;

    localparam int BIT_CLKS = 16;
`ifdef AXIS_TO_UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic [7:0] a_idata;
    logic       a_ivalid, a_iready, a_txd, a_ctsn, a_busy;
    logic [1:0] a_pm;
    logic [2:0] a_level;
    logic [4:0] b_idata;
    logic       b_ivalid, b_iready, b_txd, b_ctsn, b_busy;
    logic [1:0] b_pm;
    logic [2:0] b_level;

    int n_tests = 0;
    int n_fail  = 0;

    axis_to_uart_tx #(
        .CLOCK_FREQ (16), .BAUD_RATE (1), .DATA_BITS (8), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut_a (
        .clock (clock), .resetn (resetn), .idata (a_idata), .ivalid (a_ivalid),
        .iready (a_iready), .parity_mode (a_pm), .txd (a_txd), .ctsn (a_ctsn),
        .busy (a_busy), .level (a_level)
    );

    axis_to_uart_tx #(
        .CLOCK_FREQ (16), .BAUD_RATE (1), .DATA_BITS (5), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) dut_b (
        .clock (clock), .resetn (resetn), .idata (b_idata), .ivalid (b_ivalid),
        .iready (b_iready), .parity_mode (b_pm), .txd (b_txd), .ctsn (b_ctsn),
        .busy (b_busy), .level (b_level)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 0) ? a_txd : b_txd;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? a_iready : b_iready;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, stop 1s. Returns bit count.
    function automatic int build_frame(input int dbits, input int sbits, input logic [8:0] w,
                                       input logic [1:0] pm, output logic [15:0] bits);
        int  n;
        logic p;
        n    = 0;
        p    = 1'b0;
        bits = '0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < dbits; i++) begin
            bits[n] = w[i];
            p       = p ^ w[i];
            n++;
        end
        if (PARITY_BUILT && (pm == 2'b01 || pm == 2'b10)) begin
            bits[n] = (pm == 2'b10) ? ~p : p;
            n++;
        end
        for (int i = 0; i < sbits; i++) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int sel, input logic [8:0] w, input int limit, output bit ok);
        int n;
        n = 0;
        if (sel == 0) begin a_idata = w[7:0]; a_ivalid = 1'b1; end
        else          begin b_idata = w[4:0]; b_ivalid = 1'b1; end
        while (!ready_of(sel) && n < limit) begin
            @(negedge clock);
            n++;
        end
        ok = ready_of(sel);
        @(negedge clock);
        if (sel == 0) a_ivalid = 1'b0;
        else          b_ivalid = 1'b0;
    endtask

    // Waits for a start bit (gap = idle clocks seen first), then checks every clock of the frame.
    task automatic expect_frame(input int sel, input logic [8:0] w, input logic [1:0] pm,
                                input int max_wait, output int gap);
        logic [15:0] exp_bits, obs_bits;
        int nb, bad;
        nb       = build_frame((sel == 0) ? 8 : 5, (sel == 0) ? 1 : 2, w, pm, exp_bits);
        gap      = 0;
        bad      = 0;
        obs_bits = '0;
        @(negedge clock);
        while (line_of(sel) == 1'b1 && gap < max_wait) begin
            @(negedge clock);
            gap++;
        end
        if (line_of(sel) == 1'b1) begin
            check_val("frame_start_timeout", 32'(line_of(sel)), 32'd0);
            return;
        end
        check_val("busy_in_frame", 32'(busy_of(sel)), 32'd1);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (b != 0 || c != 0) @(negedge clock);
                if (line_of(sel) !== exp_bits[b]) bad++;
                if (c == BIT_CLKS / 2) obs_bits[b] = line_of(sel);
            end
        end
        check_val("frame_bits", 32'(obs_bits), 32'(exp_bits));
        check_val("bit_timing_errors", bad, 0);
    endtask

    logic [8:0] words [4];
    bit         ok, ok1, ok2;
    int         gap, low_seen, t, nw, sel;

    initial begin
        resetn = 1'b0;
        a_ivalid = 1'b0; a_idata = '0; a_ctsn = 1'b0; a_pm = 2'b00;
        b_ivalid = 1'b0; b_idata = '0; b_ctsn = 1'b0; b_pm = 2'b00;
        repeat (3) @(negedge clock);
        check_val("reset_txd", 32'(a_txd), 32'd1);
        check_val("reset_iready", 32'(a_iready), 32'd0);
        check_val("reset_busy", 32'(a_busy), 32'd0);
        check_val("reset_level", 32'(a_level), 32'd0);
        check_val("reset_txd_b", 32'(b_txd), 32'd1);
        resetn = 1'b1;
        check_val("iready_before_edge", 32'(a_iready), 32'd0);
        @(negedge clock);
        check_val("iready_after_reset", 32'(a_iready), 32'd1);
        check_val("iready_after_reset_b", 32'(b_iready), 32'd1);

        // 8N1 0x55 with accept-to-start latency
        push(0, 9'h055, 20, ok);
        check_val("push_55", 32'(ok), 32'd1);
        expect_frame(0, 9'h055, 2'b00, 40, gap);
        check_val("start_latency", gap, 2);
        @(negedge clock);
        check_val("idle_busy", 32'(a_busy), 32'd0);

        // parity modes on 0x07
        a_pm = 2'b01;
        push(0, 9'h007, 20, ok);
        expect_frame(0, 9'h007, a_pm, 40, gap);
        a_pm = 2'b10;
        push(0, 9'h007, 20, ok);
        expect_frame(0, 9'h007, a_pm, 40, gap);
        a_pm = 2'b11;
        push(0, 9'h0A3, 20, ok);
        expect_frame(0, 9'h0A3, a_pm, 40, gap);

        // full FIFO while CTS holds off, then back-to-back drain
        a_ctsn = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            words[i] = 9'($urandom_range(0, 255));
            push(0, words[i], 20, ok);
            check_val("push_fill", 32'(ok), 32'd1);
        end
        check_val("level_full", 32'(a_level), 32'd4);
        check_val("iready_full", 32'(a_iready), 32'd0);
        push(0, 9'h0FF, 10, ok);
        check_val("push_when_full", 32'(ok), 32'd0);
        check_val("level_still_full", 32'(a_level), 32'd4);
        a_ctsn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_frame(0, words[i], a_pm, 40, gap);
            if (i > 0) check_val("b2b_gap", gap, 0);
        end

        // ctsn rises halfway through the data bits of the first of two frames
        words[0] = 9'($urandom_range(0, 255));
        words[1] = 9'($urandom_range(0, 255));
        fork
            begin
                push(0, words[0], 20, ok1);
                push(0, words[1], 20, ok2);
            end
            begin
                expect_frame(0, words[0], a_pm, 40, gap);
            end
            begin
                t = 0;
                while (a_txd && t < 40) begin @(negedge clock); t++; end
                repeat (BIT_CLKS + 4 * BIT_CLKS) @(negedge clock);
                a_ctsn = 1'b1;
            end
        join
        check_val("cts_push_ok", 32'({ok1, ok2}), 32'd3);
        low_seen = 0;
        repeat (200) begin
            @(negedge clock);
            if (!a_txd) low_seen++;
        end
        check_val("held_by_cts", low_seen, 0);
        check_val("level_held", 32'(a_level), 32'd1);
        a_ctsn = 1'b0;
        expect_frame(0, words[1], a_pm, 40, gap);

        // reset pulse in the middle of the data bits
        push(0, 9'h0C3, 20, ok);
        push(0, 9'h03C, 20, ok);
        t = 0;
        while (a_txd && t < 40) begin @(negedge clock); t++; end
        repeat (3 * BIT_CLKS) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_val("rst_mid_txd", 32'(a_txd), 32'd1);
        check_val("rst_mid_level", 32'(a_level), 32'd0);
        check_val("rst_mid_busy", 32'(a_busy), 32'd0);
        check_val("rst_mid_iready", 32'(a_iready), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        check_val("rst_iready_low", 32'(a_iready), 32'd0);
        @(negedge clock);
        check_val("rst_iready_rise", 32'(a_iready), 32'd1);
        low_seen = 0;
        repeat (200) begin
            @(negedge clock);
            if (!a_txd) low_seen++;
        end
        check_val("fifo_flushed", low_seen, 0);

        // 5 data bits, 2 stop bits, 0x1F
        push(1, 9'h01F, 20, ok);
        expect_frame(1, 9'h01F, b_pm, 40, gap);
        check_val("start_latency_b", gap, 2);

        // randomized batches on both instances
        for (int batch = 0; batch < 10; batch++) begin
            sel = (batch < 6) ? 0 : 1;
            nw  = $urandom_range(1, 4);
            if (sel == 0) a_pm = 2'($urandom_range(0, 3));
            else          b_pm = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                words[i] = (sel == 0) ? 9'($urandom_range(0, 255)) : 9'($urandom_range(0, 31));
            end
            fork
                begin
                    for (int i = 0; i < nw; i++) begin
                        push(sel, words[i], 20, ok1);
                        check_val("rand_push", 32'(ok1), 32'd1);
                    end
                end
                begin
                    for (int j = 0; j < nw; j++) begin
                        expect_frame(sel, words[j], (sel == 0) ? a_pm : b_pm, 40, gap);
                        if (j > 0) check_val("rand_b2b_gap", gap, 0);
                    end
                end
            join
            @(negedge clock);
            check_val("rand_idle_busy", 32'(busy_of(sel)), 32'd0);
            check_val("rand_idle_level", (sel == 0) ? 32'(a_level) : 32'(b_level), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_to_uart_tx.md
AXIS_TO_UART_TX -- requirements
Module: axis_to_uart_tx

Interface
REQ-001 Parameter CLOCK_FREQ, default 133000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line rate; BAUD_COUNT = CLOCK_FREQ / BAUD_RATE (integer), legal range 2 and above.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, input buffer entries; power of two, 2 or more.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 idata  input  DATA_BITS  AXI-stream word to send.
REQ-009 ivalid  input  1  AXI-stream valid.
REQ-010 iready  output  1  AXI-stream ready.
REQ-011 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-012 txd  output  1  serial line, idle high; connects to receiver RXD.
REQ-013 ctsn  input  1  flow control, low = may send; connects to receiver RTSn; asynchronous to clock.
REQ-014 busy  output  1  high while a frame is on the line.
REQ-015 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Handshake: a word SHALL be accepted on a rising edge with ivalid && iready; iready SHALL equal (level != FIFO_DEPTH), registered, independent of ivalid.
REQ-017 A simultaneous push and pop SHALL leave level unchanged; a push when full SHALL be impossible by construction.
REQ-018 ctsn SHALL pass through a two-flop synchronizer before use.
REQ-019 States: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START SHALL occur when the FIFO is non-empty and synchronized ctsn is low; the word pops on that edge, and txd goes low on that same edge.
REQ-021 Latency: with the FIFO empty and ctsn low, txd SHALL fall on the third rising edge after the accepting edge.
REQ-022 Each bit SHALL last exactly BAUD_COUNT clocks; the baud counter SHALL restart on every IDLE -> START transition.
REQ-023 The frame SHALL be 1 start bit (0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
REQ-024 parity_mode SHALL be sampled on IDLE -> START and held for the frame; even mode sends XOR of the data bits, odd mode sends its inverse.
REQ-025 ctsn rising mid-frame SHALL NOT abort the frame; at most one further frame start is tolerated.
REQ-026 After the final stop bit the block SHALL return to IDLE; back-to-back frames SHALL have zero idle clocks.
REQ-027 busy SHALL be high in every state except IDLE.

Reset
REQ-028 On resetn low, at any time including mid-frame: txd=1, iready=0, busy=0, level=0, FIFO emptied, state=IDLE, synchronizer flops=1 (ctsn deasserted).
REQ-029 iready SHALL rise on the first clock edge after resetn deasserts.

Configuration
REQ-030 Macro AXIS_TO_UART_TX_PARITY_EN defined: parity_mode is honoured and the PARITY state exists.
REQ-031 Macro absent: parity_mode is ignored, no parity logic is built, and frames never contain a parity bit.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum typedef and the parity_mode encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-033 Baud counting SHALL be a sub-module uart_baud_gen (inputs: clock, resetn, restart; output: one-clock tick every BAUD_COUNT clocks).

Verification (CLOCK_FREQ=16, BAUD_RATE=1, so BAUD_COUNT=16)
REQ-034 DATA_BITS=8, parity none, STOP_BITS=1, send 0x55 -> txd pattern 0,1,0,1,0,1,0,1,0,1, each bit held 16 clocks, 160 clocks total.
REQ-035 Parity enabled, even mode, send 0x07 -> parity bit 1; odd mode, same word -> parity bit 0.
REQ-036 FIFO_DEPTH=4, ctsn high, push 5 words -> iready low after the 4th push, level=4; release ctsn -> all 4 frames sent back-to-back with no idle gap.
REQ-037 ctsn goes high halfway through the data bits -> current frame completes; no new start bit appears later than 3 clocks after ctsn rose.
REQ-038 resetn pulsed low mid-DATA -> txd=1 and level=0 immediately; after release, iready=1 one clock later.
REQ-039 DATA_BITS=5, STOP_BITS=2, send 0x1F -> frame of 8 bits (0,1,1,1,1,1,1,1), 128 clocks total.
